// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   Receiver for an 8N1 serial line: idle high, one low start bit, eight data
//   bits LSB first, one high stop bit. The asynchronous line is brought into
//   the clock domain with a two-flop synchroniser, and each bit is sampled at
//   its midpoint. Received bytes are offered on a valid/ready stream backed by
//   a single holding register.
//
//   Stream handshake: a byte moves to the consumer in any cycle where
//   byte_out_valid && byte_out_ready are both high. While valid is high and
//   ready is low, byte_out_valid and byte_out_data hold steady. Only rst can
//   change them in that case.
//
// Ports
//   clk             in   single clock for all logic
//   rst             in   synchronous, active-high reset
//   bit_in          in   asynchronous serial line, idle high
//   byte_out_data   out  [7:0] received byte, stable while byte_out_valid
//   byte_out_valid  out  holding register contains a byte
//   byte_out_ready  in   consumer accepts the byte this cycle
//   frame_err       out  1-cycle pulse, stop bit sampled low (byte dropped)
//   overrun         out  1-cycle pulse, byte completed while holding register
//                        was full and not being drained (new byte dropped)
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] byte_out_data,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TICKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT      = TICKS_PER_BIT / 2;
    localparam int CW            = $clog2(TICKS_PER_BIT) + 1;

    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(HALF_BIT - 1);

    generate
        if (TICKS_PER_BIT < 4) begin : g_bad_cfg
            $fatal(1, "uart_rx: TICKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser: both flops reset to the idle line level.
    logic r_sync1;
    logic r_rx_s;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;

    logic       w_sample_bit;
    logic       w_byte_done;
    logic       w_stop_bad;

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bit_in;
            r_rx_s  <= r_sync1;
        end
    end

    // Next-state logic. START waits half a bit so that every later sample
    // lands one full bit period further on, which is mid-bit. STOP exits at
    // its midpoint, so a start edge that follows immediately is still caught.
    always_comb begin
        w_state_next = r_state;
        w_sample_bit = 1'b0;
        w_byte_done  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_TICK) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_cnt == LAST_TICK) begin
                    w_sample_bit = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == LAST_TICK) begin
                    w_state_next = S_IDLE;
                    if (r_rx_s) w_byte_done = 1'b1;
                    else        w_stop_bad  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_next;
            // The counter restarts on any state change and at every data bit
            // boundary, so each comparison counts from the last decision.
            if (r_state == S_IDLE || w_state_next != r_state || w_sample_bit)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state == S_START)
                r_bit_idx <= '0;
            else if (w_sample_bit)
                r_bit_idx <= r_bit_idx + 3'd1;
            // Right shift: the first (LSB) bit ends up in bit 0 after eight samples.
            if (w_sample_bit)
                r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    // Holding register. A completing byte may replace a byte that is being
    // drained in the same cycle. If the held byte is not being drained, the
    // new byte is dropped and overrun is pulsed instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                if (!r_valid || byte_out_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && byte_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign byte_out_data  = r_data;
    assign byte_out_valid = r_valid;
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Bench for uart_rx at 16 clocks per bit. The serial driver builds 8N1
//   frames from byte values. The reference model is a queue of bytes that the
//   consumer must see, in order, plus counts of expected error pulses.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int TPB    = CLK_HZ / BAUD;   // 16 clocks per bit

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] byte_out_data;
    logic       byte_out_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk            (clk),
        .rst            (rst),
        .bit_in         (bit_in),
        .byte_out_data  (byte_out_data),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (ready),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int fe_exp = 0;
    int ov_exp = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int valid_cycles = 0;
    int xfer_cnt = 0;
    int last_rise_cyc = -1;
    int stop_cyc = 0;
    int ready_mode = 0;          // 0: ready high, 1: ready low, 2: random

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: consumes transfers against the expected queue, checks that a
    // stalled byte holds steady, and counts error pulses.
    logic       held_valid = 1'b0;
    logic [7:0] held_data  = 8'h00;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (byte_out_valid) valid_cycles++;
            if (byte_out_valid && !prev_valid) last_rise_cyc = cyc;
            if (held_valid)
                check_eq("hold_stable", {23'd0, byte_out_valid, byte_out_data}, {23'd0, 1'b1, held_data});
            if (byte_out_valid && ready) begin
                xfer_cnt++;
                check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("byte_data", 32'(byte_out_data), 32'(exp_q.pop_front()));
            end
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (frame_err && overrun) check_eq("err_exclusive", 32'd1, 32'd0);
            held_valid = byte_out_valid && !ready;
            held_data  = byte_out_data;
            prev_valid = byte_out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = 1'b0;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Drives one frame. abort_bit >= 0 pulses rst for one cycle mid-way
    // through that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int abort_bit);
        bit_in = 1'b0;
        tick(TPB);
        for (int j = 0; j < 8; j++) begin
            bit_in = b[j];
            if (j == abort_bit) begin
                tick(TPB / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                tick(TPB - TPB / 2 - 1);
            end else begin
                tick(TPB);
            end
        end
        bit_in   = stop_val;
        stop_cyc = cyc;
        tick(TPB);
        bit_in = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int base_x;
    int base_v;
    logic [7:0] rb;

    initial begin
        tick(3);
        check_eq("rst_valid", 32'(byte_out_valid), 32'd0);
        check_eq("rst_data", 32'(byte_out_data), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(5);

        // 1: single byte, latency and single valid cycle
        base_v = valid_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        tick(20);
        check_eq("t1_latency", 32'(last_rise_cyc - stop_cyc), 32'd11);
        check_eq("t1_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
        check_eq("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: short low glitch rejected, then a real byte
        base_x = xfer_cnt;
        bit_in = 1'b0;
        tick(3);
        bit_in = 1'b1;
        tick(40);
        check_eq("t2_glitch_no_byte", 32'(xfer_cnt - base_x), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        tick(20);
        check_eq("t2_one_byte", 32'(xfer_cnt - base_x), 32'd1);
        check_eq("t2_frame_err", 32'(fe_seen), 32'(fe_exp));

        // 3: bad stop bit
        base_v = valid_cycles;
        send_frame(8'h55, 1'b0, -1);
        fe_exp++;
        tick(40);
        check_eq("t3_frame_err", 32'(fe_seen), 32'(fe_exp));
        check_eq("t3_no_valid", 32'(valid_cycles - base_v), 32'd0);

        // 4: overrun with consumer stalled
        ready_mode = 1;
        tick(2);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        ov_exp++;
        tick(20);
        check_eq("t4_valid_held", 32'(byte_out_valid), 32'd1);
        check_eq("t4_data_held", 32'(byte_out_data), 32'h01);
        check_eq("t4_overrun", 32'(ov_seen), 32'(ov_exp));
        ready_mode = 0;
        tick(5);
        check_eq("t4_valid_cleared", 32'(byte_out_valid), 32'd0);
        check_eq("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: back-to-back frames without idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        tick(20);
        check_eq("t5_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t5_no_errors", 32'(fe_seen + ov_seen), 32'(fe_exp + ov_exp));

        // 6: reset during data bit 4 aborts the frame
        base_v = valid_cycles;
        send_frame(8'hF0, 1'b1, 4);
        tick(40);
        check_eq("t6_aborted_silent", 32'(valid_cycles - base_v), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        tick(20);
        check_eq("t6_drained", 32'(exp_q.size()), 32'd0);

        // Random frames, random consumer ready, occasional bad stop bits
        ready_mode = 2;
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
                fe_exp++;
                send_frame(rb, 1'b0, -1);
                tick(32);
            end else begin
                exp_q.push_back(rb);
                send_frame(rb, 1'b1, -1);
                tick($urandom_range(0, 40));
            end
        end
        ready_mode = 0;
        tick(40);

        check_eq("final_drained", 32'(exp_q.size()), 32'd0);
        check_eq("final_frame_err", 32'(fe_seen), 32'(fe_exp));
        check_eq("final_overrun", 32'(ov_seen), 32'(ov_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
